// File: rtl/vme_cmd_arbiter.sv
// vme_cmd_arbiter: round-robin sharing of one VME command/data port among NREQ sources.
// Define VME_ARB_TIMEOUT_EN to end a stalled WAIT after TIMEOUT cycles with rsp_err=1.
module vme_cmd_arbiter #(
  parameter int          NREQ    = 4,
  parameter logic [31:0] MASK    = 32'h00A80000,
  parameter int          TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [32*NREQ-1:0]   req_cmd,
  input  logic [32*NREQ-1:0]   req_dat,
  output logic [NREQ-1:0]      ack,
  output logic [15:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  input  logic                 vme_cmd_rd,
  input  logic                 vme_dat_wr,
  input  logic [31:0]          vme_dat_reg_out,
  output logic                 start,
  output logic [31:0]          vme_cmd_reg,
  output logic [31:0]          vme_dat_reg_in
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, idx, gnt;
  logic [IW:0] j;
  logic rd, rd_g, grant, fin, tmo, start_n, busy_n;
  logic [15:0] dat, rsp_n;
  logic [31:0] cmd_i, cmd_n, dat_n;
  logic [NREQ-1:0] ack_n;
  logic [31:0] cmd_a [NREQ];
  logic [31:0] dat_a [NREQ];
  logic unused_hi;
  assign unused_hi = ^vme_dat_reg_out[31:16];
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign cmd_a[i] = req_cmd[32*i +: 32];
    assign dat_a[i] = req_dat[32*i +: 32];
  end
  // first set request at or after ptr, wrapping; lowest offset wins
  always_comb begin
    gnt = ptr;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (IW+1)'(k);
      j = (j >= (IW+1)'(NREQ)) ? j - (IW+1)'(NREQ) : j;
      gnt = req[j[IW-1:0]] ? j[IW-1:0] : gnt;
    end
  end
  assign grant = vme_cmd_rd && |req;
  assign rd_g  = req_rd[gnt];
  assign cmd_i = cmd_a[gnt] | MASK;
  assign fin   = vme_dat_wr || tmo;
`ifdef VME_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign tmo = (state == WAIT) && (cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      cnt <= (state == WAIT) ? cnt + CW'(1) : '0;
      if (state == WAIT && fin) rsp_err <= !vme_dat_wr;
    end
`else
  assign tmo = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_comb
    state_n = (state == IDLE)  ? (grant ? ISSUE : IDLE) :
              (state == ISSUE) ? WAIT :
              (state == WAIT)  ? (fin ? DONE : WAIT) : IDLE;
  always_comb begin
    start_n = (state == IDLE) && grant;
    cmd_n   = start_n ? {cmd_i[31:26], rd_g, ~rd_g, cmd_i[23:0]} : MASK;
    dat_n   = (start_n && !rd_g) ? dat_a[gnt] : '0;
    ack_n   = (state == WAIT && fin) ? NREQ'(1'b1) << idx : '0;
    rsp_n   = vme_dat_wr ? (rd ? vme_dat_reg_out[15:0] : dat) : 16'hDEAD;
    busy_n  = (state == IDLE) ? grant : (state != DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      idx            <= '0;
      rd             <= 1'b0;
      dat            <= '0;
      start          <= 1'b0;
      vme_cmd_reg    <= MASK;
      vme_dat_reg_in <= '0;
      ack            <= '0;
      rsp_data       <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      start          <= start_n;
      vme_cmd_reg    <= cmd_n;
      vme_dat_reg_in <= dat_n;
      ack            <= ack_n;
      busy           <= busy_n;
      if (start_n) begin
        idx <= gnt;
        rd  <= rd_g;
        dat <= dat_a[gnt][15:0];
      end
      if (|ack_n) rsp_data <= rsp_n;
      if (state == DONE) ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
    end
endmodule
